// File: rtl/i2c_controller_if.sv
// i2c_controller_if: bundles the SCL-rate clock, the Go request and the
// datapath control strobes that pass between the I2C master controller and
// its surrounding shift register, SDA mux and baud generator.
//
// Signals:
//   ClockI2C     SCL-rate clock, synchronous to the system clock
//   Go           level request to start one transaction
//   BaudEnable   enables the SCL baud generator
//   WriteLoad    parallel-load strobe for the transmit shift register
//   ReadorWrite  0 = master drives SDA, 1 = SDA released
//   Select       SDA source: 0 = shift-register MSB, 1 = StartStopAck
//   ShiftorHold  one-clock shift strobe for the shift register
//   StartStopAck bit driven on SDA when Select = 1
//
// Modports: master = controller side, slave = environment side.
interface i2c_controller_if;
    logic ClockI2C;
    logic Go;
    logic BaudEnable;
    logic WriteLoad;
    logic ReadorWrite;
    logic Select;
    logic ShiftorHold;
    logic StartStopAck;

    modport master (
        input  ClockI2C,
        input  Go,
        output BaudEnable,
        output WriteLoad,
        output ReadorWrite,
        output Select,
        output ShiftorHold,
        output StartStopAck
    );

    modport slave (
        output ClockI2C,
        output Go,
        input  BaudEnable,
        input  WriteLoad,
        input  ReadorWrite,
        input  Select,
        input  ShiftorHold,
        input  StartStopAck
    );
endinterface

// File: rtl/i2c_controller.sv
// i2c_controller: control FSM for a single-transaction I2C master.
// Each Go request runs START, one transmitted byte, the slave ACK slot, one
// received byte, a master NACK and STOP. The block only sequences the
// external shift register, SDA source mux and SDA enable; it never touches
// the bus pins. All pacing comes from edges of the SCL-rate ClockI2C.
//
// Ports:
//   clock  system clock, all state changes on its rising edge
//   Reset  asynchronous, active-high reset
//   bus    i2c_controller_if.master (ClockI2C, Go in; control strobes out)
module i2c_controller (
    input  logic               clock,
    input  logic               Reset,
    i2c_controller_if.master   bus
);

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StLoad       = 3'd1,
        StStart      = 3'd2,
        StTxByte     = 3'd3,
        StSlaveAck   = 3'd4,
        StRxByte     = 3'd5,
        StMasterNack = 3'd6,
        StStop       = 3'd7
    } state_e;

    state_e     state;
    state_e     state_next;
    logic [3:0] count;
    logic [3:0] count_next;
    logic       prev;
    logic       pos;
    logic       neg;
    logic       time_out;

    // One-clock-wide edge strobes of ClockI2C.
    assign pos = bus.ClockI2C & ~prev;
    assign neg = ~bus.ClockI2C & prev;

    // Both byte states advance on SCL falling edges, so the last bit is the
    // falling edge seen with count already at 7.
    assign time_out = (count == 4'd7) & neg;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state <= StIdle;
            count <= 4'd0;
            prev  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            prev  <= bus.ClockI2C;
        end
    end

    // Next state, bit counter and the shift strobe.
    always_comb begin
        state_next      = state;
        count_next      = count;
        bus.ShiftorHold = 1'b0;
        unique case (state)
            StIdle: begin
                if (bus.Go) state_next = StLoad;
            end
            StLoad: begin
                if (pos) state_next = StStart;
            end
            StStart: begin
                if (neg) begin
                    state_next = StTxByte;
                    count_next = 4'd0;
                end
            end
            StTxByte: begin
                // The first bit is already on SDA from the load, so only seven
                // shifts are needed; the eighth fall ends the byte.
                if (time_out) begin
                    state_next = StSlaveAck;
                    count_next = 4'd0;
                end else if (neg) begin
                    bus.ShiftorHold = 1'b1;
                    count_next      = count + 4'd1;
                end
            end
            StSlaveAck: begin
                if (neg) begin
                    state_next = StRxByte;
                    count_next = 4'd0;
                end
            end
            StRxByte: begin
                // Sample SDA while SCL is high; count bits on the falls.
                if (pos) bus.ShiftorHold = 1'b1;
                if (time_out) begin
                    state_next = StMasterNack;
                    count_next = 4'd0;
                end else if (neg) begin
                    count_next = count + 4'd1;
                end
            end
            StMasterNack: begin
                if (neg) state_next = StStop;
            end
            StStop: begin
                if (pos) state_next = StIdle;
            end
            default: begin
                state_next = StIdle;
            end
        endcase
    end

    // Moore outputs.
    always_comb begin
        bus.BaudEnable   = (state != StIdle);
        bus.WriteLoad    = (state == StLoad);
        bus.ReadorWrite  = (state == StSlaveAck) || (state == StRxByte);
        bus.Select       = !((state == StTxByte) || (state == StRxByte));
        // Low in Start and Stop so SDA moves while SCL is high.
        bus.StartStopAck = !((state == StStart) || (state == StTxByte) || (state == StStop));
    end

endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: self-checking bench for i2c_controller. A phase-level
// reference model (phase = protocol step, counted SCL edges per step) predicts
// state, bit count, Moore outputs and the shift strobe every clock.
module tb_i2c_controller;

    logic clock = 1'b0;
    logic Reset = 1'b1;

    i2c_controller_if bus ();

    i2c_controller dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #4 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    int unsigned hp    = 3;    // ClockI2C half period in system clocks
    int unsigned hcnt  = 0;
    logic        scl_prev = 1'b0;

    // Reference model: current protocol phase and edges counted within it.
    int ph    = 0;
    int edges = 0;

    // ClockI2C generator: changes 1 ns after a rising clock edge.
    initial begin
        bus.ClockI2C = 1'b0;
        forever begin
            @(posedge clock);
            scl_prev = bus.ClockI2C;
            #1;
            if (hcnt + 1 >= hp) begin
                bus.ClockI2C = ~bus.ClockI2C;
                hcnt = 0;
            end else begin
                hcnt++;
            end
        end
    end

    // Required {BaudEnable, WriteLoad, ReadorWrite, Select, StartStopAck}.
    function automatic logic [4:0] phase_outputs(input int p);
        case (p)
            0:       return 5'b00011;
            1:       return 5'b11011;
            2:       return 5'b10010;
            3:       return 5'b10000;
            4:       return 5'b10111;
            5:       return 5'b10101;
            6:       return 5'b10011;
            default: return 5'b10010;
        endcase
    endfunction

    // SCL edges a phase must see before it is complete.
    function automatic int need(input int p);
        return (p == 3 || p == 5) ? 8 : 1;
    endfunction

    function automatic logic [12:0] observed();
        logic [2:0] s;
        s = dut.state;
        return {s, dut.count, bus.BaudEnable, bus.WriteLoad, bus.ReadorWrite,
                bus.Select, bus.StartStopAck, bus.ShiftorHold};
    endfunction

    function automatic logic [12:0] expected();
        logic       rise;
        logic       fall;
        logic       sh;
        logic [3:0] c;
        rise = bus.ClockI2C & ~scl_prev;
        fall = ~bus.ClockI2C & scl_prev;
        c    = (ph == 3 || ph == 5) ? 4'(edges) : 4'd0;
        sh   = (ph == 3 && fall && edges < 7) || (ph == 5 && rise);
        return {3'(ph), c, phase_outputs(ph), sh};
    endfunction

    // Move the model to the next clock and wait for it.
    task automatic advance();
        logic rise;
        logic fall;
        logic want;
        rise = bus.ClockI2C & ~scl_prev;
        fall = ~bus.ClockI2C & scl_prev;
        if (ph == 0) begin
            if (bus.Go) begin
                ph    = 1;
                edges = 0;
            end
        end else begin
            want = (ph == 1 || ph == 7) ? rise : fall;
            if (want) begin
                edges++;
                if (edges == need(ph)) begin
                    ph    = (ph + 1) % 8;
                    edges = 0;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        logic [12:0] exp;
        bus.Go = 1'b0;
        #3;
        obs = observed();
        total++;
        if (obs !== 13'b000_0000_00011_0) begin
            bad++;
            $display("FAIL reset_during got=%b required=%b", obs, 13'b000_0000_00011_0);
        end
        #3 Reset = 1'b0;
        @(negedge clock);
        obs = observed();
        exp = expected();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_after got=%b required=%b", obs, exp);
        end
    endtask

    task automatic test_transaction(input int unsigned half, input bit hold_go);
        logic [12:0] obs;
        logic [12:0] exp;
        int steps = 0;
        int tx = 0;
        int rx = 0;
        int mis = 0;
        bit started = 0;
        hp = half;
        bus.Go = 1'b1;
        while (!(started && ph == 0) && steps < 2000) begin
            obs = observed();
            exp = expected();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL txn t=%0t got=%b required=%b", $time, obs, exp);
            end
            if (bus.ShiftorHold) begin
                if (ph == 3) begin
                    tx++;
                end else if (ph == 5) begin
                    rx++;
                    if (!(bus.ClockI2C && !scl_prev)) mis++;
                end
            end
            advance();
            steps++;
            if (ph != 0) started = 1;
        end
        total++;
        if (steps >= 2000) begin
            bad++;
            $display("FAIL txn_timeout steps=%0d required<2000", steps);
        end
        total++;
        if (tx != 7) begin
            bad++;
            $display("FAIL tx_shifts got=%0d required=7", tx);
        end
        total++;
        if (rx != 8) begin
            bad++;
            $display("FAIL rx_shifts got=%0d required=8", rx);
        end
        total++;
        if (mis != 0) begin
            bad++;
            $display("FAIL rx_shift_align off_edge=%0d required=0", mis);
        end
        if (!hold_go) bus.Go = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [12:0] obs;
        logic [12:0] exp;
        logic [2:0]  s;
        int unsigned h;
        h = $urandom_range(2, 5);
        test_transaction(h, 1'b1);
        obs = observed();
        exp = expected();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL b2b_idle got=%b required=%b", obs, exp);
        end
        advance();
        s = dut.state;
        total++;
        if (s !== 3'd1 || bus.WriteLoad !== 1'b1) begin
            bad++;
            $display("FAIL b2b_retrigger state=%0d wl=%b required state=1 wl=1", s, bus.WriteLoad);
        end
        test_transaction(h, 1'b0);
    endtask

    task automatic test_go_noise();
        logic [12:0] obs;
        logic [12:0] exp;
        int steps = 0;
        hp = $urandom_range(2, 5);
        for (int i = 0; i < 400; i++) begin
            bus.Go = 1'($urandom_range(0, 1));
            obs = observed();
            exp = expected();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL go_noise t=%0t got=%b required=%b", $time, obs, exp);
            end
            advance();
        end
        bus.Go = 1'b0;
        while (ph != 0 && steps < 2000) begin
            obs = observed();
            exp = expected();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL go_noise_drain t=%0t got=%b required=%b", $time, obs, exp);
            end
            advance();
            steps++;
        end
        total++;
        if (steps >= 2000) begin
            bad++;
            $display("FAIL go_noise_timeout steps=%0d required<2000", steps);
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] obs;
        logic [12:0] exp;
        int steps = 0;
        hp = $urandom_range(2, 5);
        bus.Go = 1'b1;
        while (!(ph == 3 && edges == 4) && steps < 2000) begin
            obs = observed();
            exp = expected();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL mid_run t=%0t got=%b required=%b", $time, obs, exp);
            end
            advance();
            steps++;
        end
        total++;
        if (dut.count !== 4'd4) begin
            bad++;
            $display("FAIL mid_count got=%0d required=4", dut.count);
        end
        #1 Reset = 1'b1;
        #1;
        obs = observed();
        total++;
        if (obs !== 13'b000_0000_00011_0) begin
            bad++;
            $display("FAIL mid_async_reset got=%b required=%b", obs, 13'b000_0000_00011_0);
        end
        bus.Go = 1'b0;
        #1 Reset = 1'b0;
        ph    = 0;
        edges = 0;
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            obs = observed();
            exp = expected();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL post_reset_idle got=%b required=%b", obs, exp);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_transaction(3, 1'b0);
        test_transaction(2, 1'b0);
        test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            test_transaction($urandom_range(2, 5), 1'b0);
        end
        test_go_noise();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
